id_ex_stage: RTL and testbench

//  ID/EX pipeline register directly downstream of the instruction controller.

---
 rtl/id_ex_stage.sv | 95 +++++++++
 tb/tb_id_ex_stage.sv | 132 +++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with load-use bubble insertion, flush, hold and a bubble counter.
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [15:0]       id_muxctrl,
  input  logic [2:0]        id_memctrl,
  input  logic [4:0]        id_aluctrl,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_dst,
  input  logic [DATA_W-1:0] id_rd1,
  input  logic [DATA_W-1:0] id_rd2,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [DATA_W-1:0] id_pc,
  input  logic              flush,
  input  logic              hold,
  output logic [15:0]       ex_muxctrl,
  output logic [2:0]        ex_memctrl,
  output logic [4:0]        ex_aluctrl,
  output logic [REG_AW-1:0] ex_rs,
  output logic [REG_AW-1:0] ex_rt,
  output logic [REG_AW-1:0] ex_dst,
  output logic [DATA_W-1:0] ex_rd1,
  output logic [DATA_W-1:0] ex_rd2,
  output logic [DATA_W-1:0] ex_imm,
  output logic [DATA_W-1:0] ex_pc,
  output logic              ex_valid,
  output logic              stall_front,
  output logic [CNT_W-1:0]  bubble_cnt
);
  localparam logic [4:0] BUBBLE_ALU = 5'b01101;
  logic [15:0]       r_muxctrl;
  logic [2:0]        r_memctrl;
  logic [4:0]        r_aluctrl;
  logic [REG_AW-1:0] r_rs, r_rt, r_dst;
  logic [DATA_W-1:0] r_rd1, r_rd2, r_imm, r_pc;
  logic              r_valid;
  logic [CNT_W-1:0]  r_cnt;
  logic              w_uses_rt, w_load_use;
  assign w_uses_rt   = ~id_muxctrl[8] | id_memctrl[1];
  assign w_load_use  = r_valid & r_memctrl[2] & (r_dst != '0) & id_valid &
                       ((r_dst == id_rs) | (w_uses_rt & (r_dst == id_rt)));
  assign stall_front = hold | (w_load_use & ~flush);
  always_ff @(posedge clk) begin
    if (reset) begin
      r_muxctrl <= '0;
      r_memctrl <= '0;
      r_aluctrl <= BUBBLE_ALU;
      r_valid   <= 1'b0;
      r_rs      <= '0;
      r_rt      <= '0;
      r_dst     <= '0;
      r_rd1     <= '0;
      r_rd2     <= '0;
      r_imm     <= '0;
      r_pc      <= '0;
      r_cnt     <= '0;
    end else if (flush | (~hold & w_load_use)) begin
      r_muxctrl <= '0;
      r_memctrl <= '0;
      r_aluctrl <= BUBBLE_ALU;
      r_valid   <= 1'b0;
      if (~flush & ~&r_cnt) r_cnt <= r_cnt + 1'b1;
    end else if (~hold) begin
      r_muxctrl <= id_valid ? id_muxctrl : '0;
      r_memctrl <= id_valid ? id_memctrl : '0;
      r_aluctrl <= id_valid ? id_aluctrl : BUBBLE_ALU;
      r_valid   <= id_valid;
      r_rs      <= id_rs;
      r_rt      <= id_rt;
      r_dst     <= id_dst;
      r_rd1     <= id_rd1;
      r_rd2     <= id_rd2;
      r_imm     <= id_imm;
      r_pc      <= id_pc;
    end
  end
  assign ex_muxctrl = r_muxctrl;
  assign ex_memctrl = r_memctrl;
  assign ex_aluctrl = r_aluctrl;
  assign ex_rs      = r_rs;
  assign ex_rt      = r_rt;
  assign ex_dst     = r_dst;
  assign ex_rd1     = r_rd1;
  assign ex_rd2     = r_rd2;
  assign ex_imm     = r_imm;
  assign ex_pc      = r_pc;
  assign ex_valid   = r_valid;
  assign bubble_cnt = r_cnt;
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: scoreboard bench for id_ex_stage; a narrow counter makes saturation reachable.
module tb_id_ex_stage;
  localparam int DW = 32, AW = 5, CW = 2;
  localparam logic [4:0] BALU = 5'b01101;
  logic clk = 1'b0;
  logic reset, id_valid, flush, hold;
  logic [15:0] id_muxctrl;
  logic [2:0] id_memctrl;
  logic [4:0] id_aluctrl;
  logic [AW-1:0] id_rs, id_rt, id_dst;
  logic [DW-1:0] id_rd1, id_rd2, id_imm, id_pc;
  logic [15:0] ex_muxctrl;
  logic [2:0] ex_memctrl;
  logic [4:0] ex_aluctrl;
  logic [AW-1:0] ex_rs, ex_rt, ex_dst;
  logic [DW-1:0] ex_rd1, ex_rd2, ex_imm, ex_pc;
  logic ex_valid, stall_front;
  logic [CW-1:0] bubble_cnt;
  id_ex_stage #(.DATA_W(DW), .REG_AW(AW), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_muxctrl(id_muxctrl),
    .id_memctrl(id_memctrl), .id_aluctrl(id_aluctrl), .id_rs(id_rs), .id_rt(id_rt),
    .id_dst(id_dst), .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm), .id_pc(id_pc),
    .flush(flush), .hold(hold), .ex_muxctrl(ex_muxctrl), .ex_memctrl(ex_memctrl),
    .ex_aluctrl(ex_aluctrl), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_dst(ex_dst),
    .ex_rd1(ex_rd1), .ex_rd2(ex_rd2), .ex_imm(ex_imm), .ex_pc(ex_pc),
    .ex_valid(ex_valid), .stall_front(stall_front), .bubble_cnt(bubble_cnt)
  );
  always #5 clk = ~clk;
  typedef struct packed {
    logic [15:0] mux;
    logic [2:0] mem;
    logic [4:0] alu;
    logic [AW-1:0] rs, rt, dst;
    logic [DW-1:0] rd1, rd2, imm, pc;
    logic v;
    logic [CW-1:0] cnt;
  } st_t;
  st_t m;
  st_t q[$];
  int n_cmp = 0, n_bad = 0;
  task automatic check(input string tag, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask
  task automatic step();
    st_t e;
    logic uses_rt, lu;
    #1;
    uses_rt = ~id_muxctrl[8] | id_memctrl[1];
    lu = m.v & m.mem[2] & (m.dst != 0) & id_valid &
         ((m.dst == id_rs) | (uses_rt & (m.dst == id_rt)));
    if (!reset) check("stall_front", 256'(stall_front), 256'(hold | (lu & ~flush)));
    e = m;
    if (reset) begin
      e = '0;
      e.alu = BALU;
    end else if (flush) begin
      e.mux = 0; e.mem = 0; e.alu = BALU; e.v = 0;
    end else if (!hold) begin
      if (lu) begin
        e.mux = 0; e.mem = 0; e.alu = BALU; e.v = 0;
        e.cnt = (m.cnt == {CW{1'b1}}) ? m.cnt : m.cnt + 1'b1;
      end else begin
        e.v = id_valid;
        e.mux = id_valid ? id_muxctrl : 16'h0;
        e.mem = id_valid ? id_memctrl : 3'b0;
        e.alu = id_valid ? id_aluctrl : BALU;
        e.rs = id_rs; e.rt = id_rt; e.dst = id_dst;
        e.rd1 = id_rd1; e.rd2 = id_rd2; e.imm = id_imm; e.pc = id_pc;
      end
    end
    q.push_back(e);
    @(posedge clk);
    #1;
    e = q.pop_front();
    m = e;
    check("ctrl", 256'({ex_muxctrl, ex_memctrl, ex_aluctrl, ex_valid}), 256'({e.mux, e.mem, e.alu, e.v}));
    check("data", 256'({ex_rs, ex_rt, ex_dst, ex_rd1, ex_rd2, ex_imm, ex_pc}),
          256'({e.rs, e.rt, e.dst, e.rd1, e.rd2, e.imm, e.pc}));
    check("bubble_cnt", 256'(bubble_cnt), 256'(e.cnt));
  endtask
  task automatic ins(input logic v, input logic [15:0] mux, input logic [2:0] mem,
                     input logic [4:0] alu, input logic [AW-1:0] rs, input logic [AW-1:0] rt,
                     input logic [AW-1:0] dst, input logic fl = 1'b0, input logic ho = 1'b0);
    id_valid = v; id_muxctrl = mux; id_memctrl = mem; id_aluctrl = alu;
    id_rs = rs; id_rt = rt; id_dst = dst; flush = fl; hold = ho;
    id_rd1 = $urandom; id_rd2 = $urandom; id_imm = $urandom; id_pc = $urandom;
    step();
  endtask
  initial begin
    m = '0;
    reset = 1'b1;
    ins(0, 0, 0, 0, 0, 0, 0);
    ins(0, 0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    ins(1, 16'h0000, 3'b001, 5'b00010, 1, 2, 3);
    ins(1, 16'h0104, 3'b101, 5'b00010, 2, 5, 5);
    ins(1, 16'h0000, 3'b001, 5'b00010, 5, 7, 8);
    ins(1, 16'h0000, 3'b001, 5'b00010, 5, 7, 8);
    ins(1, 16'h0104, 3'b101, 5'b00010, 1, 0, 0);
    ins(1, 16'h0000, 3'b001, 5'b00010, 0, 0, 9);
    ins(1, 16'h0104, 3'b101, 5'b00010, 2, 5, 5);
    ins(1, 16'h0104, 3'b001, 5'b00010, 4, 5, 10);
    ins(1, 16'h0104, 3'b101, 5'b00010, 2, 5, 5);
    ins(1, 16'h0000, 3'b001, 5'b00010, 5, 7, 8, 1'b1);
    ins(1, 16'h0000, 3'b001, 5'b00010, 1, 2, 3);
    ins(1, 16'h0000, 3'b001, 5'b00010, 1, 2, 3, 1'b1, 1'b1);
    ins(1, 16'h0020, 3'b001, 5'b00010, 3, 4, 6);
    for (int i = 0; i < 3; i++) ins(1, 16'h0104, 3'b110, 5'b00001, 6, 6, 7, 1'b0, 1'b1);
    ins(0, 16'hffff, 3'b111, 5'b11111, 9, 9, 9);
    reset = 1'b1;
    ins(1, 16'h0104, 3'b101, 5'b00010, 2, 5, 5);
    ins(1, 16'h0104, 3'b101, 5'b00010, 2, 5, 5);
    reset = 1'b0;
    ins(1, 16'h0104, 3'b101, 5'b00010, 2, 5, 5);
    ins(1, 16'h0104, 3'b101, 5'b00010, 5, 5, 5);
    ins(1, 16'h0104, 3'b101, 5'b00010, 5, 5, 5);
    ins(1, 16'h0000, 3'b001, 5'b00010, 5, 1, 4);
    ins(1, 16'h0000, 3'b001, 5'b00010, 5, 1, 4);
    for (int i = 0; i < 3; i++) begin
      ins(1, 16'h0104, 3'b101, 5'b00010, 1, 6, 6);
      ins(1, 16'h0000, 3'b010, 5'b00010, 2, 6, 0);
      ins(1, 16'h0000, 3'b010, 5'b00010, 2, 6, 0);
    end
    check("saturated", 256'(bubble_cnt), 256'(2'b11));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
